// File: rtl/system_time_counter.sv
// BCD MM:SS.cc stopwatch/countdown driven by rising edges of an external tick,
// with a 16-bit Avalon-MM slave for control, presets, lap capture and an expiry/wrap IRQ.
module system_time_counter #(
    parameter int TICKS_PER_UNIT = 1,
    parameter int MAX_MINUTES    = 59
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam logic [3:0]  MAX_T       = 4'(MAX_MINUTES / 10);
    localparam logic [3:0]  MAX_O       = 4'(MAX_MINUTES % 10);
    localparam logic [7:0]  MAX_MIN     = {MAX_T, MAX_O};
    localparam logic [7:0]  MAX_MIN_BIN = 8'(MAX_MINUTES);
    localparam logic [15:0] PRE_LAST    = 16'(TICKS_PER_UNIT - 1);

    // time/lap layout: {min_t, min_o, sec_t, sec_o, cs_t, cs_o}
    logic [23:0] time_q, time_d;
    logic [23:0] lap_q, lap_d;
    logic [15:0] presc_q, presc_d;
    logic        ien_q, ien_d;
    logic        down_q, down_d;
    logic        running_q, running_d;
    logic        expired_q, expired_d;
    logic        wrapped_q, wrapped_d;
    logic        tick_q, tick_d;
    logic [15:0] readdata_q, readdata_d;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Clamp on the binary value so invalid tens digits (A-F) also saturate.
    function automatic logic [7:0] clamp_min(input logic [7:0] v);
        logic [3:0] o;
        logic [7:0] bin;
        o   = clamp_digit(v[3:0], 4'd9);
        bin = {4'b0, v[7:4]} * 8'd10 + {4'b0, o};
        return (bin > MAX_MIN_BIN) ? MAX_MIN : {v[7:4], o};
    endfunction

    logic        wr, ctrl_wr, start_s, stop_s, clr_s, tick_edge, step;
    logic        cs_top, sec_top, min_top, cs_bot, sec_bot;
    logic        wrap_evt, exp_evt, start_expire, time_zero;
    logic [7:0]  cs_n, sec_n, min_n;
    logic [23:0] time_step;

    always_comb begin
        wr        = chipselect & ~write_n;
        ctrl_wr   = wr && (address == 3'd1);
        start_s   = ctrl_wr & writedata[2];
        stop_s    = ctrl_wr & writedata[3];
        clr_s     = ctrl_wr & writedata[4];
        tick_edge = tick_in & ~tick_q;
        step      = running_q & tick_edge & (presc_q == PRE_LAST) & ~clr_s;

        cs_top  = (time_q[7:0]   == 8'h99);
        sec_top = (time_q[15:8]  == 8'h59);
        min_top = (time_q[23:16] == MAX_MIN);
        cs_bot  = (time_q[7:0]   == 8'h00);
        sec_bot = (time_q[15:8]  == 8'h00);

        if (!down_q) begin
            cs_n  = cs_top ? 8'h00 : bcd_inc(time_q[7:0]);
            sec_n = !cs_top ? time_q[15:8] : (sec_top ? 8'h00 : bcd_inc(time_q[15:8]));
            min_n = !(cs_top && sec_top) ? time_q[23:16]
                  : (min_top ? 8'h00 : bcd_inc(time_q[23:16]));
        end else begin
            cs_n  = cs_bot ? 8'h99 : bcd_dec(time_q[7:0]);
            sec_n = !cs_bot ? time_q[15:8] : (sec_bot ? 8'h59 : bcd_dec(time_q[15:8]));
            min_n = !(cs_bot && sec_bot) ? time_q[23:16]
                  : ((time_q[23:16] == 8'h00) ? MAX_MIN : bcd_dec(time_q[23:16]));
        end
        time_step = {min_n, sec_n, cs_n};
        wrap_evt  = step & ~down_q & cs_top & sec_top & min_top;
        exp_evt   = step & down_q & (time_step == 24'h0);

        presc_d = presc_q;
        if (running_q && tick_edge)
            presc_d = (presc_q == PRE_LAST) ? 16'h0 : presc_q + 16'h1;
        if (clr_s)
            presc_d = 16'h0;

        time_d = time_q;
        if (step)
            time_d = time_step;
        if (wr && !running_q && address == 3'd2)
            time_d[15:0] = {clamp_digit(writedata[15:12], 4'd5),
                            clamp_digit(writedata[11:8], 4'd9),
                            clamp_digit(writedata[7:4], 4'd9),
                            clamp_digit(writedata[3:0], 4'd9)};
        if (wr && !running_q && address == 3'd3)
            time_d[23:16] = clamp_min(writedata[7:0]);
        if (clr_s)
            time_d = 24'h0;

        // Lap takes the live value before any step in this cycle.
        lap_d = lap_q;
        if (wr && (address == 3'd4 || address == 3'd5))
            lap_d = time_q;

        ien_d  = ctrl_wr ? writedata[0] : ien_q;
        down_d = ctrl_wr ? writedata[1] : down_q;

        time_zero    = clr_s | (time_q == 24'h0);
        start_expire = start_s & ~stop_s & writedata[1] & time_zero;

        running_d = running_q;
        if (exp_evt)
            running_d = 1'b0;
        if (stop_s)
            running_d = 1'b0;
        else if (start_s)
            running_d = ~start_expire;

        expired_d = expired_q;
        wrapped_d = wrapped_q;
        if (wr && address == 3'd0) begin
            expired_d = 1'b0;
            wrapped_d = 1'b0;
        end
        if (exp_evt || start_expire)
            expired_d = 1'b1;
        if (wrap_evt)
            wrapped_d = 1'b1;

        tick_d = tick_in;

        unique case (address)
            3'd0:    readdata_d = {13'b0, wrapped_q, expired_q, running_q};
            3'd1:    readdata_d = {14'b0, down_q, ien_q};
            3'd2:    readdata_d = time_q[15:0];
            3'd3:    readdata_d = {8'b0, time_q[23:16]};
            3'd4:    readdata_d = lap_q[15:0];
            3'd5:    readdata_d = {8'b0, lap_q[23:16]};
            default: readdata_d = 16'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q     <= 24'h0;
            lap_q      <= 24'h0;
            presc_q    <= 16'h0;
            ien_q      <= 1'b0;
            down_q     <= 1'b0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            wrapped_q  <= 1'b0;
            tick_q     <= 1'b0;
            readdata_q <= 16'h0;
        end else begin
            time_q     <= time_d;
            lap_q      <= lap_d;
            presc_q    <= presc_d;
            ien_q      <= ien_d;
            down_q     <= down_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
            wrapped_q  <= wrapped_d;
            tick_q     <= tick_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = ien_q & (expired_q | wrapped_q);

endmodule
